// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_chain_ctrl
//  Description : Scan-chain driver. It can capture once, then it shifts a word
//                in on SCD while it collects the previous chain contents from SO.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_capture,
    input  logic [CHAIN_LEN-1:0] i_wdata,
    input  logic                 i_so,
    output logic                 o_sce,
    output logic                 o_scd,
    output logic                 o_de,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_rdata
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAPT  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CHAIN_LEN-1:0] r_wlatch, w_wlatch_nxt;
    logic [CHAIN_LEN-1:0] r_shift, w_shift_nxt;
    logic [CHAIN_LEN-1:0] r_rdata, w_rdata_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_sce, w_sce_nxt;
    logic                 r_scd, w_scd_nxt;
    logic                 r_de, w_de_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_wlatch <= '0;
            r_shift  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_sce    <= 1'b0;
            r_scd    <= 1'b0;
            r_de     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wlatch <= w_wlatch_nxt;
            r_shift  <= w_shift_nxt;
            r_rdata  <= w_rdata_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sce    <= w_sce_nxt;
            r_scd    <= w_scd_nxt;
            r_de     <= w_de_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // r_wlatch shifts right once per shift edge, so bit 1 always holds the next SCD bit.
    always_comb begin
        w_state_nxt  = r_state;
        w_wlatch_nxt = r_wlatch;
        w_shift_nxt  = r_shift;
        w_rdata_nxt  = r_rdata;
        w_cnt_nxt    = r_cnt;
        w_sce_nxt    = r_sce;
        w_scd_nxt    = r_scd;
        w_de_nxt     = r_de;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_wlatch_nxt = i_wdata;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = '0;
                    if (i_capture) begin
                        w_state_nxt = S_CAPT;
                        w_de_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_SHIFT;
                        w_sce_nxt   = 1'b1;
                        w_scd_nxt   = i_wdata[0];
                    end
                end
            end
            S_CAPT: begin
                w_de_nxt    = 1'b0;
                w_sce_nxt   = 1'b1;
                w_scd_nxt   = r_wlatch[0];
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_shift_nxt = {i_so, r_shift[CHAIN_LEN-1:1]};
                if (r_cnt == c_LAST) begin
                    w_sce_nxt   = 1'b0;
                    w_scd_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_rdata_nxt = {i_so, r_shift[CHAIN_LEN-1:1]};
                    w_state_nxt = S_FIN;
                end else begin
                    w_cnt_nxt    = r_cnt + 1'b1;
                    w_scd_nxt    = r_wlatch[1];
                    w_wlatch_nxt = r_wlatch >> 1;
                end
            end
            S_FIN: begin
                w_done_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_sce   = r_sce;
    assign o_scd   = r_scd;
    assign o_de    = r_de;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;

endmodule
`default_nettype wire
